// File: rtl/fetch_decode.sv
// fetch_decode: sequencer stage in front of the ALU.
// Fetches one instruction word per FETCH phase over a valid/request handshake,
// decodes it into ALU operand fields, and retires the ALU result in EXEC
// (register writeback, flag capture, PC update or branch).
// Optional feature macro: FD_HALT_EN (opcode 63 parks the machine in HALT
// until reset). With it undefined, opcode 63 is an ordinary NOP.
module fetch_decode #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_data,
  output logic [5:0]  alu_instr,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [31:0] alu_reg8,
  output logic [15:0] alu_value,
  output logic        alu_highlow,
  output logic        alu_f1,
  output logic        alu_f2,
  input  logic [31:0] alu_c,
  input  logic        alu_flag,
  input  logic        alu_addrch,
  input  logic [31:0] alu_naddr,
  output logic        halted
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1
`ifdef FD_HALT_EN
    ,
    HALT  = 2'd2
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        f1_q, f1_d;
  logic        f2_q, f2_d;
  logic [31:0] regs_q [16];
  logic        wr_en;

  logic [5:0]  op;
  logic [3:0]  rd;
  logic [3:0]  ra;
  logic [3:0]  rb;

  assign op = ir_q[31:26];
  assign rd = ir_q[25:22];
  assign ra = ir_q[21:18];
  assign rb = ir_q[17:14];

  // The half-load (opcode 5) reads its A operand from rd, since rd is also the
  // value being partially overwritten; every other opcode reads A from ra.
  assign alu_instr   = op;
  assign alu_a       = (op == 6'd5) ? regs_q[rd] : regs_q[ra];
  assign alu_b       = regs_q[rb];
  assign alu_reg8    = regs_q[8];
  assign alu_value   = ir_q[15:0];
  assign alu_highlow = ir_q[16];
  assign alu_f1      = f1_q;
  assign alu_f2      = f2_q;

  // Request is gated by reset_n so memory never sees a fetch while in reset.
  assign imem_req  = reset_n && (state_q == FETCH);
  assign imem_addr = pc_q;

`ifdef FD_HALT_EN
  assign halted = (state_q == HALT);
`else
  assign halted = 1'b0;
`endif

  // Next-state logic: capture the word in FETCH, retire everything at once in EXEC.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    f1_d    = f1_q;
    f2_d    = f2_q;
    wr_en   = 1'b0;
    case (state_q)
      FETCH: begin
        if (imem_valid) begin
          ir_d    = imem_data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = FETCH;
`ifdef FD_HALT_EN
        if (op == 6'd63) state_d = HALT;
        else
`endif
        begin
          wr_en = (op <= 6'd5);
          if ((op >= 6'd8) && (op <= 6'd13)) begin
            f2_d = f1_q;
            f1_d = alu_flag;
          end
          if (((op == 6'd14) || (op == 6'd15)) && alu_addrch) pc_d = alu_naddr;
          else pc_d = pc_q + 32'd1;
        end
      end
`ifdef FD_HALT_EN
      HALT: state_d = HALT;
`endif
      default: state_d = FETCH;
    endcase
  end

  // State, PC, IR, flags and register file; reset wins over any pending writeback.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      f1_q    <= 1'b0;
      f2_q    <= 1'b0;
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      f1_q    <= f1_d;
      f2_q    <= f2_d;
      if (wr_en) regs_q[rd] <= alu_c;
    end
  end

endmodule

// File: tb/tb_fetch_decode.sv
// tb_fetch_decode: scoreboard bench for fetch_decode.
// The bench plays both instruction memory and ALU. Each issued instruction
// pushes the expected decode outputs and the expected next fetch address into
// queues; a monitor pops and compares whenever the DUT starts a fetch or sits
// in EXEC. Honours FD_HALT_EN the same way the design does.
module tb_fetch_decode;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        clock;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_data;
  logic [5:0]  alu_instr;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_reg8;
  logic [15:0] alu_value;
  logic        alu_highlow;
  logic        alu_f1;
  logic        alu_f2;
  logic [31:0] alu_c;
  logic        alu_flag;
  logic        alu_addrch;
  logic [31:0] alu_naddr;
  logic        halted;

  fetch_decode #(.RESET_PC(RESET_PC)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_data   (imem_data),
    .alu_instr   (alu_instr),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_reg8    (alu_reg8),
    .alu_value   (alu_value),
    .alu_highlow (alu_highlow),
    .alu_f1      (alu_f1),
    .alu_f2      (alu_f2),
    .alu_c       (alu_c),
    .alu_flag    (alu_flag),
    .alu_addrch  (alu_addrch),
    .alu_naddr   (alu_naddr),
    .halted      (halted)
  );

  // Free-running clock, period 10.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [5:0]  instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r8;
    logic [16:0] hv;
    logic [1:0]  flags;
  } exec_t;

  int          checks = 0;
  int          errors = 0;
  bit          monitorOn = 1'b0;
  logic        prevReq = 1'b0;
  logic [31:0] lastAddr = '0;
  exec_t       execQ[$];
  logic [31:0] fetchQ[$];

  // Architectural reference model: what the machine should hold after each retire.
  logic [31:0] mRegs [16];
  logic [31:0] mPc;
  logic        mF1;
  logic        mF2;
  bit          mHalted;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic noteUnexpected(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=event expected=none", name);
  endtask

  // Inputs change 1 time unit after the rising edge; the monitor samples on the falling edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] rType(input int op, input int rd, input int ra, input int rb);
    return {op[5:0], rd[3:0], ra[3:0], rb[3:0], 14'h0};
  endfunction

  function automatic logic [31:0] halfLoad(input int rd, input logic hl, input logic [15:0] val);
    return {6'd5, rd[3:0], 4'h0, 1'b0, hl, val};
  endfunction

  // Monitor: a fetch start is imem_req rising; EXEC is the only running state without a request.
  always @(negedge clock) begin
    if (monitorOn) begin
      if (reset_n && imem_req) begin
        if (!prevReq) begin
          checkOutput("halted_in_fetch", {31'b0, halted}, 32'd0);
          if (fetchQ.size() == 0) noteUnexpected("fetch_unexpected");
          else begin
            lastAddr = fetchQ.pop_front();
            checkOutput("fetch_addr", imem_addr, lastAddr);
          end
        end else begin
          checkOutput("imem_addr_stable", imem_addr, lastAddr);
        end
      end else if (reset_n && !imem_req && !halted) begin
        if (execQ.size() == 0) noteUnexpected("exec_unexpected");
        else begin
          exec_t e;
          e = execQ.pop_front();
          checkOutput("alu_instr", {26'b0, alu_instr}, {26'b0, e.instr});
          checkOutput("alu_a", alu_a, e.a);
          checkOutput("alu_b", alu_b, e.b);
          checkOutput("alu_reg8", alu_reg8, e.r8);
          checkOutput("alu_highlow_value", {15'b0, alu_highlow, alu_value}, {15'b0, e.hv});
          checkOutput("alu_flags", {30'b0, alu_f1, alu_f2}, {30'b0, e.flags});
        end
      end
    end
    prevReq = reset_n && imem_req;
  end

  // Reset, optionally after some FETCH wait cycles and with a stray imem_valid during reset.
  task automatic applyReset(input int waitsBefore, input logic lateValid);
    imem_valid = 1'b0;
    for (int i = 0; i < waitsBefore; i++) tick();
    reset_n    = 1'b0;
    imem_valid = lateValid;
    imem_data  = $urandom;
    tick();
    checkOutput("rst_imem_req", {31'b0, imem_req}, 32'd0);
    checkOutput("rst_imem_addr", imem_addr, RESET_PC);
    checkOutput("rst_alu_a", alu_a, 32'd0);
    checkOutput("rst_alu_b", alu_b, 32'd0);
    checkOutput("rst_alu_reg8", alu_reg8, 32'd0);
    checkOutput("rst_misc", {4'b0, alu_instr, alu_highlow, alu_value, alu_f1, alu_f2, halted, imem_req}, 32'd0);
    tick();
    imem_valid = 1'b0;
    reset_n    = 1'b1;
    for (int i = 0; i < 16; i++) mRegs[i] = '0;
    mPc     = RESET_PC;
    mF1     = 1'b0;
    mF2     = 1'b0;
    mHalted = 1'b0;
    fetchQ.push_back(RESET_PC);
    monitorOn = 1'b1;
  endtask

  // One instruction: memory answers after 'waits' cycles, the ALU returns the given results.
  task automatic applyStimulus(input logic [31:0] word, input logic [31:0] c, input logic flg,
                               input logic br, input logic [31:0] target, input int waits);
    int    op, rd, ra, rb;
    exec_t e;
    op = int'(word[31:26]);
    rd = int'(word[25:22]);
    ra = int'(word[21:18]);
    rb = int'(word[17:14]);
    imem_valid = 1'b0;
    for (int i = 0; i < waits; i++) begin
      imem_data = $urandom;
      tick();
    end
    e.instr = word[31:26];
    e.a     = (op == 5) ? mRegs[rd] : mRegs[ra];
    e.b     = mRegs[rb];
    e.r8    = mRegs[8];
    e.hv    = word[16:0];
    e.flags = {mF1, mF2};
    execQ.push_back(e);
    imem_valid = 1'b1;
    imem_data  = word;
    alu_c      = c;
    alu_flag   = flg;
    alu_addrch = br;
    alu_naddr  = target;
`ifdef FD_HALT_EN
    if (op == 63) mHalted = 1'b1;
    else
`endif
    begin
      if (op <= 5) mRegs[rd] = c;
      if (op >= 8 && op <= 13) begin
        mF2 = mF1;
        mF1 = flg;
      end
      if ((op == 14 || op == 15) && br) mPc = target;
      else mPc = mPc + 32'd1;
      fetchQ.push_back(mPc);
    end
    tick();
    imem_valid = 1'($urandom_range(0, 1));
    imem_data  = $urandom;
    tick();
    imem_valid = 1'b0;
  endtask

  // After a halting instruction: stay parked with no requests, then reset out of it.
  task automatic handleHalt();
    if (mHalted) begin
      for (int i = 0; i < 20; i++) begin
        checkOutput("halt_halted", {31'b0, halted}, 32'd1);
        checkOutput("halt_req", {31'b0, imem_req}, 32'd0);
        imem_valid = 1'($urandom_range(0, 1));
        tick();
      end
      applyReset(0, 1'b1);
    end
  endtask

  // Directed scenarios first, then a randomized instruction stream.
  initial begin
    reset_n    = 1'b0;
    imem_valid = 1'b0;
    imem_data  = '0;
    alu_c      = '0;
    alu_flag   = 1'b0;
    alu_addrch = 1'b0;
    alu_naddr  = '0;

    applyReset(0, 1'b0);
    applyStimulus(rType(20, 0, 0, 0), $urandom, 1'b1, 1'b1, 32'h55, 3);
    applyStimulus(rType(1, 1, 0, 0), 32'd5, 1'b0, 1'b0, '0, 0);
    applyStimulus(rType(1, 2, 0, 0), 32'd7, 1'b0, 1'b0, '0, 1);
    applyStimulus(rType(0, 3, 1, 2), 32'd12, 1'b1, 1'b0, '0, 0);
    applyStimulus(rType(2, 4, 3, 0), 32'h0000_1234, 1'b0, 1'b0, '0, 0);
    applyStimulus(halfLoad(4, 1'b1, 16'hBEEF), 32'hBEEF_1234, 1'b0, 1'b0, '0, 2);
    applyStimulus(rType(6, 4, 4, 4), 32'hDEAD_0000, 1'b1, 1'b1, 32'h77, 0);
    applyStimulus(rType(8, 0, 4, 3), $urandom, 1'b1, 1'b0, '0, 0);
    applyStimulus(rType(1, 8, 0, 0), 32'h0000_0040, 1'b0, 1'b0, '0, 0);
    applyStimulus(rType(14, 0, 0, 8), $urandom, 1'b0, 1'b1, mRegs[8], 0);
    applyStimulus(rType(14, 0, 0, 0), $urandom, 1'b0, 1'b0, 32'h99, 1);
    applyStimulus(rType(15, 0, 0, 0), $urandom, 1'b0, 1'b1, 32'hFFFF_FFFF, 0);
    applyStimulus(rType(40, 0, 0, 0), $urandom, 1'b1, 1'b1, 32'h12, 0);
    applyReset(2, 1'b1);
    applyStimulus(rType(9, 5, 4, 3), $urandom, 1'b0, 1'b0, '0, 0);
    applyStimulus(rType(63, 0, 0, 0), $urandom, 1'b1, 1'b1, 32'h33, 0);
    handleHalt();

    for (int n = 0; n < 300; n++) begin
      logic [31:0] w;
      logic [31:0] tgt;
      int          op;
      op = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 63));
      w  = {op[5:0], 26'($urandom)};
      case ($urandom_range(0, 2))
        0:       tgt = mRegs[8];
        1:       tgt = 32'hFFFF_FFFF;
        default: tgt = $urandom;
      endcase
      if ($urandom_range(0, 19) == 0) applyReset(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
      applyStimulus(w, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tgt,
                    int'($urandom_range(0, 3)));
      handleHalt();
    end

    tick();
    tick();
    tick();
    checkOutput("fetch_queue_drained", fetchQ.size(), 32'd0);
    checkOutput("exec_queue_drained", execQ.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
